mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one req/gnt/rvalid memory port (the port driven by the AXI-to-memory bridge and the core data port) among NUM_REQ requesters.
- Picks one requester per cycle and holds that choice until the memory grants it.
- Records the owner of each granted transaction in an in-order tag FIFO, so each rvalid/rdata goes back to the requester that issued it.
- Sits between the requesters (core LSU, axi2mem bridge, debug/DMA) and the single memory macro port.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (power of two, >=1).

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- s_req_i  in  NUM_REQ  per-requester request
- s_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_we_i  in  NUM_REQ  write enable
- s_be_i  in  NUM_REQ*BE_WIDTH  packed byte enables
- s_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- s_gnt_o  out  NUM_REQ  per-requester grant
- s_rvalid_o  out  NUM_REQ  per-requester response valid
- s_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
- m_req_o  out  1  memory request
- m_addr_o  out  ADDR_WIDTH  memory address
- m_we_o  out  1  memory write enable
- m_be_o  out  BE_WIDTH  memory byte enable
- m_wdata_o  out  DATA_WIDTH  memory write data
- m_gnt_i  in  1  memory grant
- m_rvalid_i  in  1  memory response valid
- m_rdata_i  in  DATA_WIDTH  memory read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current tag-FIFO occupancy
- err_o  out  1  sticky: rvalid received with no outstanding tag

Behaviour:
- Reset (asynchronous, reset_ni low): lock=0, lock_idx=0, rr_ptr=0, tag FIFO empty, err_o=0.
  - All outputs read 0 while reset is asserted.
  - Asserting reset mid-transaction drops all pending responses; nothing is replayed.
- Protocol (OBI-like):
  - A requester holds req and its payload stable until gnt.
  - Handshake = req & gnt in the same cycle.
  - rvalid arrives in order, earliest one cycle after the corresponding memory handshake.
- States: UNLOCKED (lock=0) and LOCKED (lock=1).
  - sel = lock_idx when LOCKED, otherwise the arbitration winner among asserted s_req_i.
- m_req_o = (LOCKED | |s_req_i) & (outstanding_o < MAX_OUTSTANDING).
  - m_addr_o, m_we_o, m_be_o, m_wdata_o are muxed from sel; combinational, zero latency.
- s_gnt_o[sel] = m_gnt_i & m_req_o. All other bits are 0. At most one bit is set.
- Transitions:
  - UNLOCKED -> LOCKED on m_req_o & ~m_gnt_i; lock_idx <= sel.
  - LOCKED -> UNLOCKED on m_gnt_i.
  - While LOCKED, new or higher-priority requests are ignored, so the memory-side payload never changes while m_req_o is high without gnt.
- On handshake:
  - sel is pushed to the tag FIFO.
  - rr_ptr <= (sel+1) mod NUM_REQ.
- On m_rvalid_i with FIFO non-empty:
  - s_rvalid_o[head] = 1 in the same cycle (combinational); the head is popped.
  - s_rdata_o = m_rdata_i always.
  - Writes also receive rvalid.
- On m_rvalid_i with FIFO empty: no s_rvalid_o; err_o <= 1 and stays set until reset.
- FIFO full (count == MAX_OUTSTANDING):
  - m_req_o = 0 even if a pop occurs in the same cycle.
  - An existing lock is retained.
- Push and pop in the same cycle: count is unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- A requester dropping req while LOCKED is a protocol violation. The arbiter still drives the locked payload and releases on gnt.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at rr_ptr; the first asserted s_req_i at index >= rr_ptr (wrapping) wins.
- Undefined: fixed priority; the lowest index wins. rr_ptr is not implemented and its logic is removed.

Test Plan:
- Single requester, memory with gnt always 1 and rvalid one cycle later:
  - Stimulus: req0 read to 0x100.
  - Response: m_addr_o=0x100 in the same cycle, s_gnt_o=01; next cycle s_rvalid_o=01 with s_rdata_o=m_rdata_i=0xDEADBEEF.
- Both requesters held high, 0x10 and 0x20, gnt=1 every cycle, MEM_ARB_RR_EN defined:
  - Response: grants alternate 01,10,01,10.
  - With the macro undefined: s_gnt_o stays 01 continuously.
- Memory holds gnt=0 for 3 cycles while req0 is active; req1 asserts in cycle 1 with MEM_ARB_RR_EN favouring it:
  - Response: m_addr_o stays req0's address all 3 cycles; gnt goes to requester 0 first, then requester 1.
- MAX_OUTSTANDING=2, gnt=1, rvalid withheld:
  - Response: two handshakes, then m_req_o=0 with outstanding_o=2.
  - Then rvalid pulses: routed to the issuers in order; requests resume the cycle after count < 2.
- Stray m_rvalid_i with empty FIFO -> no s_rvalid_o bit set; err_o=1 from the next cycle onward.
- reset_ni pulsed low with 2 outstanding:
  - Response: outstanding_o=0, err_o=0; the subsequent rvalid is ignored, sets err_o, and produces no s_rvalid_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one OBI-like req/gnt/rvalid memory port among
// NUM_REQ requesters and routes in-order responses back through a tag FIFO.
//
// Ports:
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   s_req_i/s_addr_i/...   packed requester side (slice i per requester)
//   s_gnt_o, s_rvalid_o    per-requester grant / response valid
//   s_rdata_o              response data, broadcast to all requesters
//   m_*                    single memory port
//   outstanding_o          tag-FIFO occupancy
//   err_o                  sticky: rvalid seen with no outstanding tag
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration;
// when undefined, fixed priority (lowest index wins).
module mem_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [NUM_REQ-1:0]             s_req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_addr_i,
  input  logic [NUM_REQ-1:0]             s_we_i,
  input  logic [NUM_REQ*BE_WIDTH-1:0]    s_be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_wdata_i,
  output logic [NUM_REQ-1:0]             s_gnt_o,
  output logic [NUM_REQ-1:0]             s_rvalid_o,
  output logic [DATA_WIDTH-1:0]          s_rdata_o,
  output logic                           m_req_o,
  output logic [ADDR_WIDTH-1:0]          m_addr_o,
  output logic                           m_we_o,
  output logic [BE_WIDTH-1:0]            m_be_o,
  output logic [DATA_WIDTH-1:0]          m_wdata_o,
  input  logic                           m_gnt_i,
  input  logic                           m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          m_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                           err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic ST_UNLOCKED = 1'b0;
  localparam logic ST_LOCKED   = 1'b1;

  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic          state_q;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] tag_q [MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic [IW-1:0] win;
  logic [IW-1:0] sel;
  logic [IW-1:0] head;
  logic          any_req;
  logic          full;
  logic          m_req;
  logic          hs;
  logic          pop;

`ifdef MEM_ARB_RR_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  logic [IW-1:0] rr_ptr_q;
  logic          found;
  int            j;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && s_req_i[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (sel == LAST_IDX) ? '0 : sel + IW'(1);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_req_i[k]) win = IW'(k);
    end
  end
`endif

  assign any_req = |s_req_i;
  assign sel     = (state_q == ST_LOCKED) ? lock_idx_q : win;
  assign full    = (cnt_q == FULL_CNT);
  // Full blocks new requests even if a pop lands in the same cycle.
  assign m_req   = reset_ni & ((state_q == ST_LOCKED) | any_req) & ~full;
  assign hs      = m_req & m_gnt_i;
  assign pop     = m_rvalid_i & (cnt_q != '0);
  assign head    = tag_q[rptr_q];

  always_comb begin
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    s_rdata_o  = '0;
    m_addr_o   = '0;
    m_we_o     = 1'b0;
    m_be_o     = '0;
    m_wdata_o  = '0;
    m_req_o    = m_req;
    if (hs) s_gnt_o[sel] = 1'b1;
    if (reset_ni) begin
      if (pop) s_rvalid_o[head] = 1'b1;
      s_rdata_o = m_rdata_i;
      m_addr_o  = s_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
      m_we_o    = s_we_i[sel];
      m_be_o    = s_be_i[sel*BE_WIDTH +: BE_WIDTH];
      m_wdata_o = s_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign outstanding_o = reset_ni ? cnt_q : '0;
  assign err_o         = reset_ni & err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_UNLOCKED;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
    end else begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (m_req && !m_gnt_i) begin
            state_q    <= ST_LOCKED;
            lock_idx_q <= sel;
          end
        end
        default: begin
          if (hs) state_q <= ST_UNLOCKED;
        end
      endcase
      if (hs) begin
        tag_q[wptr_q] <= sel;
        wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
      end
      unique case (1'b1)
        hs & ~pop: cnt_q <= cnt_q + CW'(1);
        pop & ~hs: cnt_q <= cnt_q - CW'(1);
        default:   cnt_q <= cnt_q;
      endcase
      if (m_rvalid_i && cnt_q == '0) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors plus hand sequences, with a
// scoreboard queue of expected response owners.
module tb_mem_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    s_req_i;
  logic [N*AW-1:0] s_addr_i;
  logic [N-1:0]    s_we_i;
  logic [N*BW-1:0] s_be_i;
  logic [N*DW-1:0] s_wdata_i;
  logic [N-1:0]    s_gnt_o;
  logic [N-1:0]    s_rvalid_o;
  logic [DW-1:0]   s_rdata_o;
  logic            m_req_o;
  logic [AW-1:0]   m_addr_o;
  logic            m_we_o;
  logic [BW-1:0]   m_be_o;
  logic [DW-1:0]   m_wdata_o;
  logic            m_gnt_i;
  logic            m_rvalid_i;
  logic [DW-1:0]   m_rdata_i;
  logic [1:0]      outstanding_o;
  logic            err_o;

  int nchk = 0;
  int nerr = 0;
  int sb[$];

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  egnt;
    logic        emreq;
    logic [31:0] eaddr;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t tbl[10];

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_req_i(s_req_i), .s_addr_i(s_addr_i),
    .s_we_i(s_we_i), .s_be_i(s_be_i),
    .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o),
    .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o),
    .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input logic [1:0] r, input logic g,
                     input logic v, input logic [31:0] d,
                     input logic [1:0] eg);
    int id;
    s_req_i    = r;
    m_gnt_i    = g;
    m_rvalid_i = v;
    m_rdata_i  = d;
    #1;
    chk("gnt", 32'(s_gnt_o), 32'(eg));
    if (v && sb.size() > 0) begin
      id = sb.pop_front();
      chk("rvalid", 32'(s_rvalid_o), 32'(1) << id);
    end else begin
      chk("rvalid_none", 32'(s_rvalid_o), 32'd0);
    end
    chk("rdata", s_rdata_o, d);
    if (eg[0]) sb.push_back(0);
    else if (eg[1]) sb.push_back(1);
  endtask

  task automatic chk_m(input string nm, input logic er,
                       input logic [31:0] ea);
    chk({nm, "_mreq"}, 32'(m_req_o), 32'(er));
    chk({nm, "_addr"}, m_addr_o, ea);
  endtask

  logic [1:0] eg;

  initial begin
    tbl[0] = '{2'b01, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h10, 2'd0};
    tbl[1] = '{2'b00, 1'b0, 1'b1, 32'h11, 2'b00, 1'b0, 32'h10, 2'd1};
    tbl[2] = '{2'b10, 1'b1, 1'b0, 32'h0,  2'b10, 1'b1, 32'h20, 2'd0};
    tbl[3] = '{2'b00, 1'b0, 1'b1, 32'h22, 2'b00, 1'b0, 32'h10, 2'd1};
    tbl[4] = '{2'b01, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 32'h10, 2'd0};
    tbl[5] = '{2'b11, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 32'h10, 2'd0};
    tbl[6] = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h10, 2'd0};
    tbl[7] = '{2'b10, 1'b1, 1'b1, 32'h33, 2'b10, 1'b1, 32'h20, 2'd1};
    tbl[8] = '{2'b00, 1'b0, 1'b1, 32'h44, 2'b00, 1'b0, 32'h10, 2'd1};
    tbl[9] = '{2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 32'h10, 2'd0};

    reset_ni   = 1'b0;
    s_req_i    = 2'b11;
    s_addr_i   = {32'h20, 32'h100};
    s_we_i     = 2'b00;
    s_be_i     = 8'hFF;
    s_wdata_i  = {32'hB, 32'hA};
    m_gnt_i    = 1'b1;
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'hFFFF;
    #2;
    chk("rst_mreq", 32'(m_req_o), 32'd0);
    chk("rst_gnt", 32'(s_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
    chk("rst_rdata", s_rdata_o, 32'd0);
    chk("rst_cnt", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    tick();
    tick();
    reset_ni = 1'b1;

    // single read to 0x100, rvalid one cycle later
    drv(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    chk_m("rd", 1'b1, 32'h100);
    tick();
    drv(2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00);
    tick();
    s_addr_i = {32'h20, 32'h10};

    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].req, tbl[i].gnt, tbl[i].rv,
          tbl[i].rdata, tbl[i].egnt);
      chk_m("tbl", tbl[i].emreq, tbl[i].eaddr);
      chk("tbl_cnt", 32'(outstanding_o), 32'(tbl[i].ecnt));
      tick();
    end

    // both requesters held high, gnt every cycle
    drv(2'b11, 1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    for (int i = 1; i < 5; i++) begin
`ifdef MEM_ARB_RR_EN
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      eg = 2'b01;
`endif
      drv(2'b11, 1'b1, 1'b1, 32'(i), eg);
      tick();
    end
    drv(2'b00, 1'b0, 1'b1, 32'h5, 2'b00);
    tick();

    // lock held across three gnt-less cycles
    drv(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    drv(2'b01, 1'b0, 1'b1, 32'hA, 2'b00);
    chk_m("lk0", 1'b1, 32'h10);
    tick();
    drv(2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    chk_m("lk1", 1'b1, 32'h10);
    tick();
    drv(2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    chk_m("lk2", 1'b1, 32'h10);
    tick();
    drv(2'b11, 1'b1, 1'b0, 32'h0, 2'b01);
    chk_m("lk3", 1'b1, 32'h10);
    tick();
    drv(2'b10, 1'b1, 1'b0, 32'h0, 2'b10);
    chk_m("lk4", 1'b1, 32'h20);
    tick();
    drv(2'b00, 1'b0, 1'b1, 32'hB, 2'b00);
    tick();
    drv(2'b00, 1'b0, 1'b1, 32'hC, 2'b00);
    tick();

    // fill to MAX_OUTSTANDING, then drain in order
    drv(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    drv(2'b10, 1'b1, 1'b0, 32'h0, 2'b10);
    tick();
    drv(2'b11, 1'b1, 1'b0, 32'h0, 2'b00);
    chk("full_mreq", 32'(m_req_o), 32'd0);
    chk("full_cnt", 32'(outstanding_o), 32'd2);
    tick();
    drv(2'b11, 1'b1, 1'b1, 32'h61, 2'b00);
    chk("full_pop_mreq", 32'(m_req_o), 32'd0);
    tick();
    drv(2'b01, 1'b1, 1'b1, 32'h62, 2'b01);
    chk("resume_mreq", 32'(m_req_o), 32'd1);
    chk("resume_cnt", 32'(outstanding_o), 32'd1);
    tick();
    drv(2'b00, 1'b0, 1'b1, 32'h63, 2'b00);
    tick();

    // stray rvalid with nothing outstanding
    drv(2'b00, 1'b0, 1'b1, 32'h70, 2'b00);
    chk("stray_err_now", 32'(err_o), 32'd0);
    tick();
    m_rvalid_i = 1'b0;
    chk("stray_err", 32'(err_o), 32'd1);
    tick();
    chk("stray_err_hold", 32'(err_o), 32'd1);

    // reset with two transactions in flight
    drv(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    drv(2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    chk("pre_rst_cnt", 32'(outstanding_o), 32'd2);
    s_req_i   = 2'b01;
    m_gnt_i   = 1'b1;
    m_rdata_i = 32'h55;
    reset_ni  = 1'b0;
    #1;
    chk("mid_rst_mreq", 32'(m_req_o), 32'd0);
    chk("mid_rst_gnt", 32'(s_gnt_o), 32'd0);
    chk("mid_rst_cnt", 32'(outstanding_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    chk("mid_rst_addr", m_addr_o, 32'd0);
    tick();
    reset_ni = 1'b1;
    s_req_i  = 2'b00;
    m_gnt_i  = 1'b0;
    sb.delete();
    #1;
    chk("post_rst_cnt", 32'(outstanding_o), 32'd0);
    chk("post_rst_err", 32'(err_o), 32'd0);
    drv(2'b00, 1'b0, 1'b1, 32'h77, 2'b00);
    tick();
    m_rvalid_i = 1'b0;
    chk("post_rst_stray_err", 32'(err_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
